// File: rtl/sys_ctrl_cmd_engine.sv
// UART command decoder: turns framed command bytes into RF writes/reads and ALU
// operations, and returns results through a valid/ready byte channel.
module sys_ctrl_cmd_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     UART_RX_DATA,
  input  logic                      UART_RX_VLD,
  input  logic [DATA_WIDTH-1:0]     RF_RdData,
  input  logic                      RF_RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      TX_RDY,
  output logic                      ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
  output logic                      CLKG_EN,
  output logic                      CLK_DIV_EN,
  output logic [ADDR_WIDTH-1:0]     RF_Address,
  output logic                      RF_WrEn,
  output logic                      RF_RdEn,
  output logic [DATA_WIDTH-1:0]     RF_WrData,
  output logic [DATA_WIDTH-1:0]     TX_DATA,
  output logic                      TX_VLD,
  output logic                      CMD_ERR,
  output logic                      BUSY
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [DATA_WIDTH-1:0] OPC_WR    = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OPC_RD    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OPC_ALU   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OPC_ALUNO = DATA_WIDTH'(8'hDD);
  localparam logic [DATA_WIDTH-1:0] OPC_BURST = DATA_WIDTH'(8'hEE);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUNC,
    ALU_WAIT, BW_ADDR, BW_LEN, BW_DATA, TX_RF, TX_LO, TX_HI
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [DATA_WIDTH-1:0]     len_reg;
  logic [2*DATA_WIDTH-1:0]   result_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      cmd_err_reg;
  logic                      tx_vld_reg;

  logic rx_state, cnt_state, byte_accept, rd_done, alu_done, progress;
  logic tx_fire, timeout_hit, illegal_op;

  always_comb begin
    rx_state  = 1'b0;
    cnt_state = 1'b1;
    case (state_reg)
      WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUNC,
      BW_ADDR, BW_LEN, BW_DATA: rx_state = 1'b1;
      IDLE, TX_RF, TX_LO, TX_HI: cnt_state = 1'b0;
      default: ;
    endcase
  end

  assign byte_accept = UART_RX_VLD && rx_state;
  assign rd_done     = (state_reg == RD_WAIT) && RF_RdData_Valid;
  assign alu_done    = (state_reg == ALU_WAIT) && ALU_OUT_VLD;
  assign progress    = byte_accept || rd_done || alu_done;
  assign tx_fire     = tx_vld_reg && TX_RDY;
  // Any forward progress in the expiring cycle beats the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && cnt_state &&
                       (cnt_reg == TO_LAST) && !progress;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    illegal_op = 1'b0;
    case (state_reg)
      IDLE: if (UART_RX_VLD) begin
        case (UART_RX_DATA)
          OPC_WR:    state_next = WR_ADDR;
          OPC_RD:    state_next = RD_ADDR;
          OPC_ALU:   state_next = OP_A;
          OPC_ALUNO: state_next = ALU_FUNC;
          OPC_BURST: state_next = BW_ADDR;
          default:   illegal_op = 1'b1;
        endcase
      end
      WR_ADDR:  if (UART_RX_VLD) state_next = WR_DATA;
      WR_DATA:  if (UART_RX_VLD) state_next = IDLE;
      RD_ADDR:  if (UART_RX_VLD) state_next = RD_WAIT;
      RD_WAIT:  if (RF_RdData_Valid) state_next = TX_RF;
      OP_A:     if (UART_RX_VLD) state_next = OP_B;
      OP_B:     if (UART_RX_VLD) state_next = ALU_FUNC;
      ALU_FUNC: if (UART_RX_VLD) state_next = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD) state_next = TX_LO;
      BW_ADDR:  if (UART_RX_VLD) state_next = BW_LEN;
      BW_LEN:   if (UART_RX_VLD)
                  state_next = (UART_RX_DATA == '0) ? IDLE : BW_DATA;
      BW_DATA:  if (UART_RX_VLD && len_reg == DATA_WIDTH'(1)) state_next = IDLE;
      TX_RF:    if (tx_fire) state_next = IDLE;
      TX_LO:    if (tx_fire) state_next = TX_HI;
      TX_HI:    if (tx_fire) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_comb begin
    ALU_EN     = 1'b0;
    ALU_FUN    = '0;
    CLKG_EN    = 1'b0;
    RF_Address = '0;
    RF_WrEn    = 1'b0;
    RF_RdEn    = 1'b0;
    RF_WrData  = '0;
    TX_DATA    = '0;
    case (state_reg)
      WR_DATA, BW_DATA: if (UART_RX_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = addr_reg;
        RF_WrData  = UART_RX_DATA;
      end
      OP_A: if (UART_RX_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = ADDR_WIDTH'(OPA_ADDR);
        RF_WrData  = UART_RX_DATA;
      end
      OP_B: if (UART_RX_VLD) begin
        RF_WrEn    = 1'b1;
        RF_Address = ADDR_WIDTH'(OPB_ADDR);
        RF_WrData  = UART_RX_DATA;
      end
      RD_WAIT: begin
        RF_RdEn    = 1'b1;
        RF_Address = addr_reg;
      end
      ALU_FUNC: begin
        CLKG_EN = 1'b1;
        if (UART_RX_VLD) begin
          ALU_EN  = 1'b1;
          ALU_FUN = UART_RX_DATA[ALU_FUN_WIDTH-1:0];
        end
      end
      ALU_WAIT:     CLKG_EN = 1'b1;
      TX_RF, TX_LO: TX_DATA = result_reg[DATA_WIDTH-1:0];
      TX_HI:        TX_DATA = result_reg[2*DATA_WIDTH-1:DATA_WIDTH];
      default: ;
    endcase
  end

  assign TX_VLD     = tx_vld_reg;
  assign CMD_ERR    = cmd_err_reg;
  assign BUSY       = (state_reg != IDLE);
  assign CLK_DIV_EN = 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_reg    <= '0;
      len_reg     <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      cmd_err_reg <= 1'b0;
      tx_vld_reg  <= 1'b0;
    end else begin
      cmd_err_reg <= illegal_op || timeout_hit;
      tx_vld_reg  <= (state_next == TX_RF) || (state_next == TX_LO) ||
                     (state_next == TX_HI);
      if (!cnt_state || (state_next != state_reg) || byte_accept ||
          (TIMEOUT_CYCLES == 0))
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;
      case (state_reg)
        WR_ADDR, RD_ADDR, BW_ADDR:
          if (UART_RX_VLD) addr_reg <= UART_RX_DATA[ADDR_WIDTH-1:0];
        BW_LEN:
          if (UART_RX_VLD) len_reg <= UART_RX_DATA;
        // Burst address wraps naturally at the RF address width.
        BW_DATA: if (UART_RX_VLD) begin
          addr_reg <= addr_reg + 1'b1;
          len_reg  <= len_reg - 1'b1;
        end
        RD_WAIT:
          if (RF_RdData_Valid) result_reg <= {{DATA_WIDTH{1'b0}}, RF_RdData};
        ALU_WAIT:
          if (ALU_OUT_VLD) result_reg <= ALU_OUT;
        default: ;
      endcase
    end
  end

endmodule
